// File: rtl/exc_pkg.sv
// Shared definitions for the exception return unit: cause codes, frame layout,
// stack occupancy states and the handler-vector helper.
package exc_pkg;

    localparam logic [2:0] CAUSE_OVF   = 3'd1;
    localparam logic [2:0] CAUSE_BRK   = 3'd2;
    localparam logic [2:0] CAUSE_DIVZ  = 3'd3;
    localparam logic [2:0] CAUSE_SSTEP = 3'd4;

    localparam int FRAME_W = 35;
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cause;
    } frame_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } stk_state_t;

    function automatic logic [31:0] exc_vector(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [2:0]  cause);
        return base + ({29'd0, cause} * stride);
    endfunction

    function automatic logic cause_valid(input logic [2:0] cause);
        logic ok;
        case (cause)
            CAUSE_OVF, CAUSE_BRK, CAUSE_DIVZ, CAUSE_SSTEP: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/exc_return_unit_if.sv
// Exception-request / redirect bundle between the EX exception detector
// (master) and the exception return unit (slave).
interface exc_return_unit_if;
    logic        exc_we;
    logic [31:0] exc_pc;
    logic [2:0]  exc_cause;
    logic        eret;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (output exc_we, exc_pc, exc_cause, eret,
                    input  redirect, redirect_pc);
    modport slave  (input  exc_we, exc_pc, exc_cause, eret,
                    output redirect, redirect_pc);
endinterface

// File: rtl/exc_frame_stack.sv
// LIFO of {pc, cause} frames with a registered occupancy pointer; exposes the
// top frame and the one beneath it so the owner can register the post-pop top.
module exc_frame_stack
    import exc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  frame_t           din,
    output frame_t           top,
    output frame_t           below,
    output logic [CNT_W-1:0] count
);

    localparam int SLOTS = 1 << CNT_W;

    frame_t           mem_r [0:SLOTS-1];
    logic [CNT_W-1:0] count_r;

    // Storage and pointer; a push on a full stack or a pop on an empty one is a no-op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push && (count_r < CNT_W'(DEPTH))) begin
            mem_r[count_r] <= din;
            count_r        <= count_r + 3'd1;
        end else if (pop && (count_r != 3'd0)) begin
            count_r <= count_r - 3'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Top-of-stack and next-below views, zero where no such frame exists.
    always_comb begin
        top   = '0;
        below = '0;
        if (count_r != 3'd0) begin
            top = mem_r[count_r - 3'd1];
        end else begin
            top = '0;
        end
        if (count_r > 3'd1) begin
            below = mem_r[count_r - 3'd2];
        end else begin
            below = '0;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/exc_return_unit.sv
// Exception entry/return sequencer feeding the PC mux. Nested frames are kept
// only when EXC_NEST_EN is defined; otherwise a single frame is held.
module exc_return_unit
    import exc_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] HANDLER_BASE = 32'h0000_0400,
    parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             rst,
    exc_return_unit_if.slave bus,
    output logic [31:0]      epc,
    output logic [2:0]       cause_q,
    output logic             in_handler,
    output logic [2:0]       depth,
    output logic             ss_active,
    output logic             ovf_err,
    output logic             uf_err,
    output logic [7:0]       drop_cnt
);

`ifdef EXC_NEST_EN
    localparam int DEPTH_EFF = DEPTH;
`else
    localparam int DEPTH_EFF = (DEPTH < 1) ? DEPTH : 1;
`endif

    stk_state_t       state_r, state_s;
    logic             req_s, push_s, pop_s, ovf_s, uf_s, eret_drop_s;
    logic [CNT_W-1:0] cnt_s, cnt_next_s;
    frame_t           top_s, below_s, top_next_s, din_s;
    logic [31:0]      rpc_s;
    logic [8:0]       drop_sum_s;
    logic [7:0]       drop_next_s;

    logic             redirect_r, in_handler_r, ss_r, ovf_r, uf_r;
    logic [31:0]      rpc_r, epc_r;
    logic [2:0]       cause_r, depth_r;
    logic [7:0]       drop_r;

    assign din_s = '{pc: bus.exc_pc, cause: bus.exc_cause};

    exc_frame_stack #(.DEPTH(DEPTH_EFF)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (din_s),
        .top   (top_s),
        .below (below_s),
        .count (cnt_s)
    );

    // Request decode: a valid exception beats a simultaneous eret, which is dropped.
    always_comb begin
        req_s       = bus.exc_we && cause_valid(bus.exc_cause);
        push_s      = req_s && (state_r != ST_FULL);
        ovf_s       = req_s && (state_r == ST_FULL);
        pop_s       = bus.eret && !req_s && (state_r != ST_EMPTY);
        uf_s        = bus.eret && !req_s && (state_r == ST_EMPTY);
        eret_drop_s = bus.eret && req_s;
        cnt_next_s  = cnt_s + {2'd0, push_s} - {2'd0, pop_s};
        drop_sum_s  = {1'b0, drop_r} + {8'd0, ovf_s} + {8'd0, uf_s} + {8'd0, eret_drop_s};
        if (drop_sum_s[8]) begin
            drop_next_s = 8'hFF;
        end else begin
            drop_next_s = drop_sum_s[7:0];
        end
        if (push_s) begin
            top_next_s = din_s;
            rpc_s      = exc_vector(HANDLER_BASE, VEC_STRIDE, bus.exc_cause);
        end else if (pop_s) begin
            top_next_s = below_s;
            rpc_s      = top_s.pc;
        end else begin
            top_next_s = top_s;
            rpc_s      = 32'd0;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Occupancy next-state: only pushes and pops move between EMPTY/ACTIVE/FULL.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_s = (DEPTH_EFF == 1) ? ST_FULL : ST_ACTIVE;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ACTIVE: begin
                if (push_s && (cnt_s == CNT_W'(DEPTH_EFF - 1))) begin
                    state_s = ST_FULL;
                end else if (pop_s && (cnt_s == 3'd1)) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_s = (DEPTH_EFF == 1) ? ST_EMPTY : ST_ACTIVE;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // Output registers, all reflecting the stack after this cycle's operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_r   <= 1'b0;
            rpc_r        <= 32'd0;
            epc_r        <= 32'd0;
            cause_r      <= 3'd0;
            depth_r      <= 3'd0;
            in_handler_r <= 1'b0;
            ss_r         <= 1'b0;
            ovf_r        <= 1'b0;
            uf_r         <= 1'b0;
            drop_r       <= 8'd0;
        end else begin
            redirect_r   <= push_s || pop_s;
            rpc_r        <= rpc_s;
            epc_r        <= top_next_s.pc;
            cause_r      <= top_next_s.cause;
            depth_r      <= cnt_next_s;
            in_handler_r <= (cnt_next_s != 3'd0);
            ss_r         <= (top_next_s.cause == CAUSE_SSTEP);
            ovf_r        <= ovf_r || ovf_s;
            uf_r         <= uf_r || uf_s;
            drop_r       <= drop_next_s;
        end
    end

    assign bus.redirect    = redirect_r;
    assign bus.redirect_pc = rpc_r;
    assign epc             = epc_r;
    assign cause_q         = cause_r;
    assign depth           = depth_r;
    assign in_handler      = in_handler_r;
    assign ss_active       = ss_r;
    assign ovf_err         = ovf_r;
    assign uf_err          = uf_r;
    assign drop_cnt        = drop_r;

endmodule

// File: tb/tb_exc_return_unit.sv
// Directed bench for exc_return_unit: a queue-based frame model checked every
// cycle, plus hand-computed expectations at key points of the sequence.
module tb_exc_return_unit;

`ifdef EXC_NEST_EN
    localparam int MAXD = 4;
`else
    localparam int MAXD = 1;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] epc;
    logic [2:0]  cause_q;
    logic        in_handler;
    logic [2:0]  depth;
    logic        ss_active;
    logic        ovf_err;
    logic        uf_err;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    exc_return_unit_if bus ();

    exc_return_unit dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .epc        (epc),
        .cause_q    (cause_q),
        .in_handler (in_handler),
        .depth      (depth),
        .ss_active  (ss_active),
        .ovf_err    (ovf_err),
        .uf_err     (uf_err),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [34:0] mq[$];
    logic        m_redirect;
    logic [31:0] m_rpc;
    logic        m_ovf, m_uf;
    int          m_drop;
    logic [34:0] m_f;
    logic        m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_redirect = 1'b0;
            m_rpc      = 32'd0;
            m_ovf      = 1'b0;
            m_uf       = 1'b0;
            m_drop     = 0;
        end else begin
            m_redirect = 1'b0;
            m_rpc      = 32'd0;
            m_valid    = bus.exc_we && (bus.exc_cause >= 3'd1) && (bus.exc_cause <= 3'd4);
            if (m_valid) begin
                if (mq.size() < MAXD) begin
                    mq.push_back({bus.exc_pc, bus.exc_cause});
                    m_redirect = 1'b1;
                    m_rpc      = 32'h0000_0400 + 32'(bus.exc_cause) * 32'h0000_0010;
                end else begin
                    m_ovf  = 1'b1;
                    m_drop = m_drop + 1;
                end
                if (bus.eret) m_drop = m_drop + 1;
            end else if (bus.eret) begin
                if (mq.size() > 0) begin
                    m_f        = mq.pop_back();
                    m_redirect = 1'b1;
                    m_rpc      = m_f[34:3];
                end else begin
                    m_uf   = 1'b1;
                    m_drop = m_drop + 1;
                end
            end
            if (m_drop > 255) m_drop = 255;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic [34:0] t;
            t = (mq.size() > 0) ? mq[mq.size()-1] : 35'd0;
            chk("redirect", 32'(bus.redirect), 32'(m_redirect));
            if (m_redirect) chk("redirect_pc", bus.redirect_pc, m_rpc);
            chk("epc", epc, t[34:3]);
            chk("cause_q", 32'(cause_q), 32'(t[2:0]));
            chk("depth", 32'(depth), 32'(mq.size()));
            chk("in_handler", 32'(in_handler), 32'(mq.size() != 0));
            chk("ss_active", 32'(ss_active), 32'(t[2:0] == 3'd4));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
            chk("uf_err", 32'(uf_err), 32'(m_uf));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic we, input logic [31:0] pc, input logic [2:0] c, input logic er);
        @(negedge clk);
        bus.exc_we    = we;
        bus.exc_pc    = pc;
        bus.exc_cause = c;
        bus.eret      = er;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_redirect"}, 32'(bus.redirect), 32'd0);
        chk({tag, "_rpc"}, bus.redirect_pc, 32'd0);
        chk({tag, "_epc"}, epc, 32'd0);
        chk({tag, "_cause"}, 32'(cause_q), 32'd0);
        chk({tag, "_inh"}, 32'(in_handler), 32'd0);
        chk({tag, "_depth"}, 32'(depth), 32'd0);
        chk({tag, "_ss"}, 32'(ss_active), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
        chk({tag, "_uf"}, 32'(uf_err), 32'd0);
        chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    endtask

    logic [31:0] ret_pcs [4] = '{32'h1030, 32'h1020, 32'h1010, 32'h1000};

    initial begin
        rst = 1'b1;
        bus.exc_we = 1'b0; bus.exc_pc = 32'd0; bus.exc_cause = 3'd0; bus.eret = 1'b0;
        repeat (2) @(negedge clk);
        all_zero("reset");
        rst = 1'b0;

        step(1'b1, 32'h100, 3'd3, 1'b0);
        chk("entry_redirect", 32'(bus.redirect), 32'd1);
        chk("entry_pc", bus.redirect_pc, 32'h430);
        chk("entry_epc", epc, 32'h100);
        chk("entry_depth", 32'(depth), 32'd1);
        step(1'b0, 32'd0, 3'd0, 1'b0);
        chk("pulse_low", 32'(bus.redirect), 32'd0);

        step(1'b0, 32'd0, 3'd0, 1'b1);
        chk("eret_pc", bus.redirect_pc, 32'h100);
        chk("eret_depth", 32'(depth), 32'd0);
        chk("eret_inh", 32'(in_handler), 32'd0);

        step(1'b0, 32'd0, 3'd0, 1'b1);
        chk("uf_redirect", 32'(bus.redirect), 32'd0);
        chk("uf_err", 32'(uf_err), 32'd1);
        chk("uf_drop", 32'(drop_cnt), 32'd1);

        step(1'b1, 32'h300, 3'd0, 1'b0);
        chk("inv_redirect", 32'(bus.redirect), 32'd0);
        chk("inv_drop", 32'(drop_cnt), 32'd1);

`ifdef EXC_NEST_EN
        step(1'b1, 32'h1000, 3'd1, 1'b0);
        step(1'b1, 32'h1010, 3'd2, 1'b0);
        step(1'b1, 32'h1020, 3'd3, 1'b0);
        step(1'b1, 32'h1030, 3'd1, 1'b0);
        chk("nest4_depth", 32'(depth), 32'd4);
        step(1'b1, 32'h1040, 3'd2, 1'b0);
        chk("full_redirect", 32'(bus.redirect), 32'd0);
        chk("full_ovf", 32'(ovf_err), 32'd1);
        chk("full_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0, 3'd0, 1'b1);
            chk("lifo_pc", bus.redirect_pc, ret_pcs[i]);
        end
`else
        step(1'b1, 32'h1000, 3'd1, 1'b0);
        step(1'b1, 32'h1010, 3'd2, 1'b0);
        chk("full_redirect", 32'(bus.redirect), 32'd0);
        chk("full_ovf", 32'(ovf_err), 32'd1);
        chk("full_drop", 32'(drop_cnt), 32'd2);
        chk("full_depth", 32'(depth), 32'd1);
        step(1'b0, 32'd0, 3'd0, 1'b1);
        chk("single_pc", bus.redirect_pc, ret_pcs[3]);
`endif
        chk("drained_depth", 32'(depth), 32'd0);

        step(1'b1, 32'h500, 3'd1, 1'b0);
        step(1'b1, 32'h200, 3'd2, 1'b1);
`ifdef EXC_NEST_EN
        chk("both_pc", bus.redirect_pc, 32'h420);
        chk("both_depth", 32'(depth), 32'd2);
        chk("both_drop", 32'(drop_cnt), 32'd3);
`else
        chk("both_redirect", 32'(bus.redirect), 32'd0);
        chk("both_depth", 32'(depth), 32'd1);
        chk("both_drop", 32'(drop_cnt), 32'd4);
`endif

        @(negedge clk);
        bus.exc_we = 1'b0; bus.eret = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 32'h600, 3'd4, 1'b0);
        chk("ss_pc", bus.redirect_pc, 32'h440);
        chk("ss_active", 32'(ss_active), 32'd1);
        step(1'b1, 32'h700, 3'd1, 1'b0);
`ifdef EXC_NEST_EN
        chk("ss_nest_depth", 32'(depth), 32'd2);
        chk("ss_nest_clear", 32'(ss_active), 32'd0);
`else
        chk("ss_keep", 32'(ss_active), 32'd1);
        chk("ss_drop", 32'(drop_cnt), 32'd1);
`endif

        @(negedge clk);
        #2;
        bus.exc_we = 1'b0; bus.eret = 1'b0;
        rst = 1'b1;
        #1;
        all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 260; i++) begin
            step(1'b0, 32'd0, 3'd0, 1'b1);
        end
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_uf", 32'(uf_err), 32'd1);
        step(1'b0, 32'd0, 3'd0, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
